// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared register offsets and status bit layout for io_port
package io_port_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_RXDATA = 2'd2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_RXFULL    = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  function automatic logic [7:0] pack_status(input logic [3:0] count,
                                             input logic ovf,
                                             input logic rx_full,
                                             input logic full,
                                             input logic empty);
    logic [7:0] s;
    s = '0;
    s[ST_EMPTY]              = empty;
    s[ST_FULL]               = full;
    s[ST_RXFULL]             = rx_full;
    s[ST_OVF]                = ovf;
    s[ST_COUNT_LSB +: 4]     = count;
    return s;
  endfunction

endpackage

// File: rtl/io_port_fifo.sv
// rtl/io_port_fifo.sv - byte_fifo: power-of-2 synchronous FIFO, no fall-through
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_port.sv
// rtl/io_port.sv - memory-mapped byte I/O: TX FIFO, RX holding register, status
module io_port
  import io_port_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [7:0] BASE  = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] addr,
  input  logic [7:0] wd,
  output logic       sel,
  output logic [7:0] rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    ofs;
  logic          push;
  logic          pop;
  logic [CW-1:0] fcount;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          ovf_set;
  logic          ovf_clr;
  logic          rx_full;
  logic [7:0]    rx_hold;
  logic          capture;
  logic          rx_clr;

  assign sel      = (addr[7:2] == BASE[7:2]);
  assign ofs      = addr[1:0];
  assign push     = we && sel && (ofs == OFS_TXDATA);
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wd),
    .head  (tx_data),
    .count (fcount),
    .full  (full),
    .empty (empty)
  );

  assign ovf_set  = push && full && !pop;
  assign ovf_clr  = re && sel && (ofs == OFS_STATUS);
  assign rx_clr   = re && sel && (ofs == OFS_RXDATA);
  assign rx_ready = !rx_full && !reset;
  assign capture  = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf     <= 1'b0;
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else begin
      ovf <= ovf_set || (ovf && !ovf_clr);
      if (capture) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_clr) begin
        rx_full <= 1'b0;
      end
    end
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      case (ofs)
        OFS_STATUS: rd = pack_status(4'(fcount), ovf, rx_full, full, empty);
        OFS_RXDATA: rd = rx_hold;
        default:    rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - self-checking bench for io_port against a queue-based model
module tb_io_port;

  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'hF0;

  logic       clk = 1'b0;
  logic       reset, we, re, tx_ready, rx_valid;
  logic [7:0] addr, wd, rx_data;
  logic       sel, tx_valid, rx_ready;
  logic [7:0] rd, tx_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_rxf;
  logic [7:0] m_hold;

  io_port #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wd(wd),
    .sel(sel), .rd(rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_status();
    int n;
    n = q.size();
    return {4'(n), m_ovf, m_rxf, (n == DEPTH), (n == 0)};
  endfunction

  function automatic logic [7:0] m_rd(input logic [7:0] a);
    if (a[7:2] != BASE[7:2]) return 8'h00;
    case (a[1:0])
      2'd1:    return m_status();
      2'd2:    return m_hold;
      default: return 8'h00;
    endcase
  endfunction

  // Advance the model by the rules of one rising edge, then the DUT clock.
  task automatic tick();
    logic in_win, pop, push, st_clr, rx_clr, cap, ovf_set;
    in_win  = (addr[7:2] == BASE[7:2]);
    pop     = (q.size() > 0) && tx_ready;
    push    = we && in_win && (addr[1:0] == 2'd0);
    st_clr  = re && in_win && (addr[1:0] == 2'd1);
    rx_clr  = re && in_win && (addr[1:0] == 2'd2);
    cap     = rx_valid && !m_rxf && !reset;
    ovf_set = 1'b0;
    if (reset) begin
      q.delete();
      m_ovf  = 1'b0;
      m_rxf  = 1'b0;
      m_hold = 8'h00;
    end else begin
      if (push && !(q.size() < DEPTH || pop)) ovf_set = 1'b1;
      if (pop) void'(q.pop_front());
      if (push && !ovf_set) q.push_back(wd);
      m_ovf = ovf_set || (m_ovf && !st_clr);
      if (rx_clr) m_rxf = 1'b0;
      if (cap) begin
        m_rxf  = 1'b1;
        m_hold = rx_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; re = 0; addr = 8'h00; wd = 8'h00;
    tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    we = 1; addr = a; wd = d; tick(); we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; #1;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready_low got=%0b exp=0", rx_ready); end
    tick(); reset = 0;
    addr = BASE + 8'd1; #1;
    checks++; if (rd !== 8'h01 || rd !== m_status()) begin errors++; $display("FAIL reset_status got=%h exp=01", rd); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got=%0b/%h exp=0/00", tx_valid, tx_data); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got=%0b exp=1", rx_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_seq [3];
    do_reset();
    store(BASE, 8'hA5);
    store(BASE, 8'h3C);
    addr = BASE + 8'd1; #1;
    checks++; if (rd !== 8'h20) begin errors++; $display("FAIL basic_status got=%h exp=20", rd); end
    exp_seq[0] = 8'hA5; exp_seq[1] = 8'h3C; exp_seq[2] = 8'h00;
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_data !== exp_seq[i] || tx_valid !== (i < 2)) begin
        errors++; $display("FAIL basic_drain[%0d] got=%h/%0b exp=%h/%0b", i, tx_data, tx_valid, exp_seq[i], (i < 2));
      end
      if (i < 2) tick();
    end
    tx_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) store(BASE, 8'(i));
    addr = BASE + 8'd1; #1;
    checks++; if (rd !== 8'h8A || rd !== m_status()) begin errors++; $display("FAIL ovf_status got=%h exp=8a", rd); end
    re = 1; tick(); re = 0;
    checks++; if (rd !== 8'h82) begin errors++; $display("FAIL ovf_cleared got=%h exp=82", rd); end
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, tx_data, 8'(i)); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", tx_valid); end
    tx_ready = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < DEPTH; i++) store(BASE, 8'($urandom_range(0, 255)));
    tx_ready = 1; we = 1; addr = BASE; wd = 8'h77; #1;
    checks++; if (tx_data !== q[0]) begin errors++; $display("FAIL b2b_head got=%h exp=%h", tx_data, q[0]); end
    tick(); we = 0; tx_ready = 0;
    addr = BASE + 8'd1; #1;
    checks++; if (rd !== 8'h82) begin errors++; $display("FAIL b2b_status got=%h exp=82", rd); end
    tx_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (tx_data !== q[0] || (i == DEPTH - 1 && tx_data !== 8'h77)) begin
        errors++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, tx_data, q[0]);
      end
      tick();
    end
    tx_ready = 0;
  endtask

  task automatic test_rx();
    do_reset();
    rx_valid = 1; rx_data = 8'h5E; tick();
    rx_data = 8'($urandom_range(0, 255));
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_after_cap got=%0b exp=0", rx_ready); end
    addr = BASE + 8'd1; #1;
    checks++; if (rd[2] !== 1'b1) begin errors++; $display("FAIL rx_full_bit got=%0b exp=1", rd[2]); end
    tick();
    rx_valid = 0; re = 1; addr = BASE + 8'd2; #1;
    checks++; if (rd !== 8'h5E) begin errors++; $display("FAIL rx_data got=%h exp=5e", rd); end
    tick(); re = 0;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_load got=%0b exp=1", rx_ready); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) store(BASE, 8'(8'h40 + i));
    rx_valid = 1; rx_data = 8'hC3; tick(); rx_valid = 0;
    reset = 1; tx_ready = 1; tick(); reset = 0; tx_ready = 0;
    addr = BASE + 8'd1; #1;
    checks++; if (rd !== 8'h01 || tx_valid !== 1'b0) begin errors++; $display("FAIL midreset got=%h/%0b exp=01/0", rd, tx_valid); end
    store(BASE + 8'd3, 8'h99);
    store(BASE + 8'd1, 8'h55);
    store(BASE + 8'd2, 8'h66);
    store(8'h10, 8'h11);
    addr = BASE + 8'd1; #1;
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL ignored_stores got=%h exp=01", rd); end
    addr = BASE + 8'd3; #1;
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reserved_read got=%h exp=00", rd); end
    addr = BASE + 8'd2; #1;
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL hold_zeroed got=%h exp=00", rd); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = BASE;
        2:       a = BASE + 8'd1;
        3:       a = BASE + 8'd2;
        4:       a = BASE + 8'd3;
        default: a = 8'($urandom_range(0, 255));
      endcase
      addr     = a;
      we       = ($urandom_range(0, 2) != 0);
      re       = ($urandom_range(0, 1) != 0);
      wd       = 8'($urandom_range(0, 255));
      tx_ready = ($urandom_range(0, 4) < 2);
      rx_valid = ($urandom_range(0, 1) != 0);
      rx_data  = 8'($urandom_range(0, 255));
      reset    = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (sel !== (a[7:2] == BASE[7:2]) || rd !== m_rd(a)) begin
        errors++; $display("FAIL rand_rd[%0d] addr=%h got=%h exp=%h", n, a, rd, m_rd(a));
      end
      checks++;
      if (tx_valid !== (q.size() > 0) || tx_data !== ((q.size() > 0) ? q[0] : 8'h00)) begin
        errors++; $display("FAIL rand_tx[%0d] got=%0b/%h exp=%0b/%h", n, tx_valid, tx_data, (q.size() > 0), (q.size() > 0) ? q[0] : 8'h00);
      end
      checks++;
      if (rx_ready !== (!m_rxf && !reset)) begin
        errors++; $display("FAIL rand_rx_ready[%0d] got=%0b exp=%0b", n, rx_ready, (!m_rxf && !reset));
      end
      tick();
      reset = 0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    q.delete(); m_ovf = 0; m_rxf = 0; m_hold = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_rx();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
